// File: rtl/spi_slave_regs_pkg.sv
// rtl/spi_slave_regs_pkg.sv - shared SPI command codes, FSM encoding and helpers
package spi_slave_regs_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_WDATA  = 3'd3;
    localparam logic [2:0] ST_RDATA  = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    // MSB-first serial shift: new bit enters at the LSB
    function automatic logic [7:0] shift_in(input logic [7:0] value, input logic bit_in);
        return {value[6:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - N-stage synchronizer with level and edge outputs
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q,
    output logic toggle
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    // Marks which stages hold samples taken after reset, so reset values never fake an edge
    logic [STAGES:0]   vld_q;

    // Shift the asynchronous input through the chain and keep one extra sample for edge detect
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            vld_q  <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
            vld_q  <= {vld_q[STAGES-1:0], 1'b1};
        end
    end

    assign q      = sync_q[STAGES-1];
    assign toggle = vld_q[STAGES] & (sync_q[STAGES-1] ^ prev_q);

endmodule

// File: rtl/spi_slave_regs.sv
// rtl/spi_slave_regs.sv - SPI mode-0 slave bridging to a byte register bus
module spi_slave_regs
    import spi_slave_regs_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck_i,
    input  logic              ncs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              busy_o,
    output logic              cmd_err_o
);

    logic                   sck_q, sck_tgl, ncs_q, ncs_tgl;
    logic                   sck_rise, sck_fall, ncs_rise, ncs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;
    logic [2:0]             state;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift, tx_shift, rx_next;
    logic                   cmd_rd, re_req, load_pend, byte_done;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk    (clk_i),
        .resetn (rst_i),
        .d      (sck_i),
        .q      (sck_q),
        .toggle (sck_tgl)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
        .clk    (clk_i),
        .resetn (rst_i),
        .d      (ncs_i),
        .q      (ncs_q),
        .toggle (ncs_tgl)
    );

    assign sck_rise = sck_tgl & sck_q;
    assign sck_fall = sck_tgl & ~sck_q;
    assign ncs_rise = ncs_tgl & ncs_q;
    assign ncs_fall = ncs_tgl & ~ncs_q;

    // Delay mosi by the same depth as sck so the sampled bit lines up with the detected rise
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
        end
    end

    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign rx_next   = shift_in(rx_shift, mosi_s);
    assign byte_done = (state != ST_IDLE) && sck_rise && (bit_cnt == 3'd7);

    // Transaction FSM, serial shifters and register-bus strobes
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            cmd_rd      <= 1'b0;
            re_req      <= 1'b0;
            load_pend   <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            cmd_err_o   <= 1'b0;
        end else begin
            reg_we_o  <= 1'b0;
            cmd_err_o <= 1'b0;
            re_req    <= 1'b0;
            reg_re_o  <= re_req;
            load_pend <= reg_re_o;

            // A write strobe is followed by the auto-increment for the next burst byte
            if (reg_we_o) begin
                reg_addr_o <= reg_addr_o + 1'b1;
            end

            // Read data lands one cycle after the read strobe; otherwise shift on falls,
            // except at the byte boundary so the fresh MSB stays on the line
            if (load_pend) begin
                tx_shift <= reg_rdata_i;
            end else if (state == ST_RDATA && sck_fall && bit_cnt != 3'd0) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end

            if (state == ST_IDLE) begin
                if (ncs_fall) begin
                    state    <= ST_CMD;
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                end
            end else begin
                if (sck_rise) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            if (rx_next == CMD_WRITE) begin
                                cmd_rd <= 1'b0;
                                state  <= ST_ADDR;
                            end else if (rx_next == CMD_READ) begin
                                cmd_rd <= 1'b1;
                                state  <= ST_ADDR;
                            end else begin
                                cmd_err_o <= 1'b1;
                                state     <= ST_IGNORE;
                            end
                        end
                        ST_ADDR: begin
                            reg_addr_o <= ADDR_W'(rx_next);
                            state      <= cmd_rd ? ST_RDATA : ST_WDATA;
                            re_req     <= cmd_rd;
                        end
                        ST_WDATA: begin
                            reg_wdata_o <= rx_next;
                            reg_we_o    <= 1'b1;
                        end
                        ST_RDATA: begin
                            reg_addr_o <= reg_addr_o + 1'b1;
                            re_req     <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                // Deselect wins over the state chosen above but a completed byte still counts
                if (ncs_rise) begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
            end
        end
    end

    assign miso_o    = (state == ST_RDATA) & tx_shift[7];
    assign miso_oe_o = ~ncs_q;
    assign busy_o    = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb/tb_spi_slave_regs.sv - directed table-driven bench for spi_slave_regs
module tb_spi_slave_regs;

    logic       clk_i = 1'b0;
    logic       rst_i, sck_i, ncs_i, mosi_i;
    logic       miso_o, miso_oe_o, reg_we_o, reg_re_o, busy_o, cmd_err_o;
    logic [7:0] reg_addr_o, reg_wdata_o;
    logic [7:0] reg_rdata_i = 8'h00;

    always #5 clk_i = ~clk_i;

    spi_slave_regs #(.SYNC_STAGES(2), .ADDR_W(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sck_i       (sck_i),
        .ncs_i       (ncs_i),
        .mosi_i      (mosi_i),
        .miso_o      (miso_o),
        .miso_oe_o   (miso_oe_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o),
        .cmd_err_o   (cmd_err_o)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] mem [256];
    int         we_n, err_n, miso_hi;
    logic [7:0] we_addr, we_data;
    logic [7:0] re_addrs [$];

    // Register file model: data valid one cycle after the read strobe
    always @(posedge clk_i) begin
        if (reg_re_o) reg_rdata_i <= mem[reg_addr_o];
    end

    // Event monitor sampled on the falling edge
    always @(negedge clk_i) begin
        if (reg_we_o) begin
            we_n++;
            we_addr = reg_addr_o;
            we_data = reg_wdata_o;
        end
        if (reg_re_o) re_addrs.push_back(reg_addr_o);
        if (cmd_err_o) err_n++;
        if (miso_o) miso_hi++;
    end

    task automatic clear_mon();
        we_n = 0; err_n = 0; miso_hi = 0;
        we_addr = 8'h00; we_data = 8'h00;
        re_addrs.delete();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Mode 0 master: drive mosi, sample miso just before each rising sck
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi_i = tx[i];
            wait_clk(6);
            rx[i] = miso_o;
            sck_i = 1'b1;
            wait_clk(6);
            sck_i = 1'b0;
        end
    endtask

    task automatic ncs_start();
        ncs_i = 1'b0;
        wait_clk(6);
    endtask

    task automatic ncs_end();
        wait_clk(6);
        ncs_i = 1'b1;
        wait_clk(10);
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         we_n;
        logic [7:0] we_addr, we_data;
        int         re_n;
        logic [7:0] re_addr0, rx2, addr_after;
        int         err_n;
        logic       quiet;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] r0, r1, r2, r3;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'hAD;
        mem[8'h7F] = 8'h3C;
        mem[8'hFE] = 8'h11;
        mem[8'hFF] = 8'h22;

        vecs[0] = '{8'h0A, 8'h2D, 8'h02, 1, 8'h2D, 8'h02, 0, 8'h00, 8'h00, 8'h2E, 0, 1'b1};
        vecs[1] = '{8'h0B, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 2, 8'h00, 8'hAD, 8'h01, 0, 1'b0};
        vecs[2] = '{8'h0A, 8'hFF, 8'h5A, 1, 8'hFF, 8'h5A, 0, 8'h00, 8'h00, 8'h00, 0, 1'b1};
        vecs[3] = '{8'h0B, 8'h7F, 8'h00, 0, 8'h00, 8'h00, 2, 8'h7F, 8'h3C, 8'h80, 0, 1'b0};
        vecs[4] = '{8'h55, 8'h12, 8'h34, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h80, 1, 1'b1};

        rst_i = 1'b0; ncs_i = 1'b1; sck_i = 1'b0; mosi_i = 1'b0;
        clear_mon();
        wait_clk(3);
        check("rst miso", miso_o, 0);
        check("rst miso_oe", miso_oe_o, 0);
        check("rst busy", busy_o, 0);
        check("rst addr", reg_addr_o, 0);
        check("rst wdata", reg_wdata_o, 0);
        check("rst strobes", {reg_we_o, reg_re_o, cmd_err_o}, 0);
        rst_i = 1'b1;
        wait_clk(5);

        for (int v = 0; v < 5; v++) begin
            clear_mon();
            ncs_start();
            check($sformatf("v%0d busy", v), busy_o, 1);
            spi_bits(vecs[v].b0, 8, r0);
            spi_bits(vecs[v].b1, 8, r1);
            spi_bits(vecs[v].b2, 8, r2);
            ncs_end();
            check($sformatf("v%0d we count", v), we_n, vecs[v].we_n);
            if (vecs[v].we_n > 0) begin
                check($sformatf("v%0d we addr", v), we_addr, vecs[v].we_addr);
                check($sformatf("v%0d we data", v), we_data, vecs[v].we_data);
            end
            check($sformatf("v%0d re count", v), re_addrs.size(), vecs[v].re_n);
            if (vecs[v].re_n > 0 && re_addrs.size() > 0)
                check($sformatf("v%0d re addr", v), re_addrs[0], vecs[v].re_addr0);
            check($sformatf("v%0d miso cmd/addr", v), {r0, r1}, 16'h0000);
            check($sformatf("v%0d miso data", v), r2, vecs[v].rx2);
            check($sformatf("v%0d addr after", v), reg_addr_o, vecs[v].addr_after);
            check($sformatf("v%0d err pulses", v), err_n, vecs[v].err_n);
            if (vecs[v].quiet) check($sformatf("v%0d miso quiet", v), miso_hi, 0);
            check($sformatf("v%0d idle", v), busy_o, 0);
        end

        // Read burst across the address wrap
        clear_mon();
        ncs_start();
        spi_bits(8'h0B, 8, r0);
        spi_bits(8'hFE, 8, r0);
        spi_bits(8'h00, 8, r1);
        spi_bits(8'h00, 8, r2);
        spi_bits(8'h00, 8, r3);
        ncs_end();
        check("burst data0", r1, 8'h11);
        check("burst data1", r2, 8'h22);
        check("burst data2", r3, 8'hAD);
        check("burst re count", re_addrs.size(), 4);
        if (re_addrs.size() >= 3) begin
            check("burst re addr0", re_addrs[0], 8'hFE);
            check("burst re addr1", re_addrs[1], 8'hFF);
            check("burst re addr2", re_addrs[2], 8'h00);
        end
        check("burst we", we_n, 0);

        // Deselect after 5 data bits discards the partial byte
        clear_mon();
        ncs_start();
        spi_bits(8'h0A, 8, r0);
        spi_bits(8'h10, 8, r0);
        spi_bits(8'hA7, 5, r0);
        ncs_i = 1'b1;
        wait_clk(10);
        check("abort we", we_n, 0);
        check("abort idle", busy_o, 0);
        check("abort addr", reg_addr_o, 8'h10);
        clear_mon();
        ncs_start();
        spi_bits(8'h0A, 8, r0);
        spi_bits(8'h2D, 8, r0);
        spi_bits(8'h02, 8, r0);
        ncs_end();
        check("post-abort we count", we_n, 1);
        check("post-abort we addr", we_addr, 8'h2D);
        check("post-abort we data", we_data, 8'h02);

        // Reset in the middle of the write data byte
        clear_mon();
        ncs_start();
        spi_bits(8'h0A, 8, r0);
        spi_bits(8'h33, 8, r0);
        spi_bits(8'hC3, 4, r0);
        rst_i = 1'b0;
        wait_clk(2);
        check("midrst miso", miso_o, 0);
        check("midrst miso_oe", miso_oe_o, 0);
        check("midrst busy", busy_o, 0);
        check("midrst addr", reg_addr_o, 0);
        check("midrst wdata", reg_wdata_o, 0);
        check("midrst strobes", {reg_we_o, reg_re_o, cmd_err_o}, 0);
        rst_i = 1'b1;
        wait_clk(2);
        spi_bits(8'h0F, 4, r0);
        wait_clk(10);
        check("midrst no we", we_n, 0);
        check("midrst stays idle", busy_o, 0);
        ncs_i = 1'b1;
        wait_clk(10);
        clear_mon();
        ncs_start();
        spi_bits(8'h0A, 8, r0);
        spi_bits(8'h44, 8, r0);
        spi_bits(8'h99, 8, r0);
        ncs_end();
        check("post-rst we count", we_n, 1);
        check("post-rst we addr", we_addr, 8'h44);
        check("post-rst we data", we_data, 8'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
